// File: rtl/fsm_flow_ctrl_param.sv
// Flow-control supervisor for NUM_FIFOS FIFOs with clamped thresholds and idle hysteresis.
// Optional macro FSM_ERR_RECOVERY_EN: leave ERROR through init when FIFO errors are clear.
module fsm_flow_ctrl_param #(
    parameter int              NUM_FIFOS = 5,
    parameter int              TH_W      = 8,
    parameter logic [TH_W-1:0] MAX_TH    = 8'd255,
    parameter int              IDLE_HOLD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [TH_W-1:0]      UMF,
    input  logic [TH_W-1:0]      UVC,
    input  logic [TH_W-1:0]      UD,
    input  logic [NUM_FIFOS-1:0] FIFO_ERROR,
    input  logic [NUM_FIFOS-1:0] FIFO_EMPTY,
    output logic [TH_W-1:0]      UMF_OUT,
    output logic [TH_W-1:0]      UVC_OUT,
    output logic [TH_W-1:0]      UD_OUT,
    output logic                 error_out,
    output logic                 active_out,
    output logic                 idle_out,
    output logic                 init_out,
    output logic [2:0]           state_out,
    output logic [NUM_FIFOS-1:0] error_src
);

    localparam int CW = (IDLE_HOLD > 0) ? $clog2(IDLE_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD = CW'(IDLE_HOLD);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       idle_cnt, idle_cnt_n;
    logic [NUM_FIFOS-1:0] src_n;
    logic [TH_W-1:0]     umf_n, uvc_n, ud_n;
    logic                any_err, all_empty;

    function automatic logic [TH_W-1:0] clamp(input logic [TH_W-1:0] v);
        return (v > MAX_TH) ? MAX_TH : v;
    endfunction

    assign any_err   = |FIFO_ERROR;
    assign all_empty = &FIFO_EMPTY;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_RESET;
            idle_cnt  <= '0;
            error_src <= '0;
            UMF_OUT   <= '0;
            UVC_OUT   <= '0;
            UD_OUT    <= '0;
        end else begin
            state     <= state_n;
            idle_cnt  <= idle_cnt_n;
            error_src <= src_n;
            UMF_OUT   <= umf_n;
            UVC_OUT   <= uvc_n;
            UD_OUT    <= ud_n;
        end
    end

    always_comb begin
        state_n    = state;
        idle_cnt_n = '0;
        src_n      = error_src;
        umf_n      = UMF_OUT;
        uvc_n      = UVC_OUT;
        ud_n       = UD_OUT;
        if (state != S_RESET) src_n = error_src | FIFO_ERROR;
        case (state)
            S_RESET: state_n = S_INIT;
            S_INIT: begin
                umf_n = clamp(UMF);
                uvc_n = clamp(UVC);
                ud_n  = clamp(UD);
                if (any_err)        state_n = S_ERROR;
                else if (init)      state_n = S_INIT;
                else if (all_empty) state_n = S_IDLE;
                else                state_n = S_ACTIVE;
            end
            S_IDLE: begin
                if (any_err)         state_n = S_ERROR;
                else if (init)       state_n = S_INIT;
                else if (!all_empty) state_n = S_ACTIVE;
            end
            S_ACTIVE: begin
                // counter only survives while staying in ACTIVE on all-empty cycles
                if (any_err)        state_n = S_ERROR;
                else if (init)      state_n = S_INIT;
                else if (all_empty) begin
                    if (idle_cnt == HOLD) state_n = S_IDLE;
                    else idle_cnt_n = idle_cnt + CW'(1);
                end
            end
            S_ERROR: begin
`ifdef FSM_ERR_RECOVERY_EN
                if (init && !any_err) begin
                    state_n = S_INIT;
                    src_n   = '0;
                end
`else
                state_n = S_ERROR;
`endif
            end
            default: state_n = S_RESET;
        endcase
    end

    assign state_out  = state;
    assign error_out  = (state == S_ERROR);
    assign active_out = (state == S_ACTIVE);
    assign idle_out   = (state == S_IDLE);
    assign init_out   = (state == S_INIT);

endmodule

// File: tb/tb_fsm_flow_ctrl_param.sv
// Directed bench for fsm_flow_ctrl_param with a behavioural reference model.
module tb_fsm_flow_ctrl_param;

    localparam int N = 5;
    localparam int W = 8;
    localparam logic [W-1:0] MAXT = 8'h40;
    localparam int HOLD = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         init = 1'b0;
    logic [W-1:0] umf = '0, uvc = '0, ud = '0;
    logic [N-1:0] ferr = '0, femp = 5'h1F;
    logic [W-1:0] umf_o, uvc_o, ud_o;
    logic         err_o, act_o, idle_o, init_o;
    logic [2:0]   st_o;
    logic [N-1:0] src_o;

    int tests = 0;
    int fails = 0;

    fsm_flow_ctrl_param #(
        .NUM_FIFOS(N), .TH_W(W), .MAX_TH(MAXT), .IDLE_HOLD(HOLD)
    ) dut (
        .clk(clk), .reset(rst_n), .init(init),
        .UMF(umf), .UVC(uvc), .UD(ud),
        .FIFO_ERROR(ferr), .FIFO_EMPTY(femp),
        .UMF_OUT(umf_o), .UVC_OUT(uvc_o), .UD_OUT(ud_o),
        .error_out(err_o), .active_out(act_o), .idle_out(idle_o),
        .init_out(init_o), .state_out(st_o), .error_src(src_o)
    );

    always #5 clk = ~clk;

    // reference model: states as plain codes, m_run counts all-empty ACTIVE edges seen
    logic [2:0]   m_st = '0;
    logic [W-1:0] m_umf = '0, m_uvc = '0, m_ud = '0;
    logic [N-1:0] m_src = '0;
    int           m_run = 0;
    logic         m_ae, m_al;
    assign m_ae = (ferr != '0);
    assign m_al = (femp == 5'h1F);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 3'd0; m_umf <= '0; m_uvc <= '0; m_ud <= '0;
            m_src <= '0; m_run <= 0;
        end else begin
            if (m_st != 3'd0) m_src <= m_src | ferr;
            case (m_st)
                3'd0: m_st <= 3'd1;
                3'd1: begin
                    m_umf <= (umf > MAXT) ? MAXT : umf;
                    m_uvc <= (uvc > MAXT) ? MAXT : uvc;
                    m_ud  <= (ud > MAXT) ? MAXT : ud;
                    m_st  <= m_ae ? 3'd4 : init ? 3'd1 : m_al ? 3'd2 : 3'd3;
                end
                3'd2: m_st <= m_ae ? 3'd4 : init ? 3'd1 : !m_al ? 3'd3 : 3'd2;
                3'd3: begin
                    if (m_ae || init) begin
                        m_st <= m_ae ? 3'd4 : 3'd1; m_run <= 0;
                    end else if (!m_al) m_run <= 0;
                    else if (m_run + 1 > HOLD) begin
                        m_st <= 3'd2; m_run <= 0;
                    end else m_run <= m_run + 1;
                end
                default: begin
`ifdef FSM_ERR_RECOVERY_EN
                    if (init && !m_ae) begin
                        m_st <= 3'd1; m_src <= '0;
                    end
`endif
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("m_state", 32'(st_o), 32'(m_st));
        check("m_err", 32'(err_o), 32'(m_st == 3'd4));
        check("m_act", 32'(act_o), 32'(m_st == 3'd3));
        check("m_idle", 32'(idle_o), 32'(m_st == 3'd2));
        check("m_init", 32'(init_o), 32'(m_st == 3'd1));
        check("m_umf", 32'(umf_o), 32'(m_umf));
        check("m_uvc", 32'(uvc_o), 32'(m_uvc));
        check("m_ud", 32'(ud_o), 32'(m_ud));
        check("m_src", 32'(src_o), 32'(m_src));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(); tick();
        check("rst_state", 32'(st_o), 0);
        check("rst_thr", {8'h0, umf_o, uvc_o, ud_o}, 0);
        // release with init held
        rst_n = 1'b1; init = 1'b1;
        umf = 8'h10; uvc = 8'h20; ud = 8'h30;
        tick(); check("seq1", 32'(st_o), 1);
        tick(); check("seq2", 32'(st_o), 1);
        tick(); check("seq3", 32'(st_o), 1);
        init = 1'b0;
        tick(); check("seq4", 32'(st_o), 2);
        check("thr", {8'h0, umf_o, uvc_o, ud_o}, 32'h00102030);
        check("idle_flag", 32'(idle_o), 1);
        // clamp
        init = 1'b1; umf = 8'hFF;
        tick(); tick();
        init = 1'b0;
        tick();
        check("clamp", 32'(umf_o), 32'h40);
        check("clamp_st", 32'(st_o), 2);
        // idle -> active, hysteresis with restart
        femp = 5'h1B; tick(); check("to_active", 32'(st_o), 3);
        femp = 5'h1F; tick();
        femp = 5'h1B; tick();
        femp = 5'h1F; tick(); tick();
        check("hold_restart", 32'(st_o), 3);
        tick(); check("idle_after3", 32'(st_o), 2);
        femp = 5'h1B; tick();
        femp = 5'h1F; tick(); tick();
        check("hold2", 32'(st_o), 3);
        tick(); check("hold3", 32'(st_o), 2);
        // error beats init
        femp = 5'h1B; tick();
        ferr = 5'b00100; init = 1'b1;
        tick();
        check("err_st", 32'(st_o), 4);
        check("err_src1", 32'(src_o), 32'h04);
        ferr = '0; init = 1'b0; tick();
        ferr = 5'b00001; tick();
        check("err_src2", 32'(src_o), 32'h05);
        check("err_thr", {8'h0, umf_o, uvc_o, ud_o}, 32'h00402030);
        ferr = '0; init = 1'b1; tick();
`ifdef FSM_ERR_RECOVERY_EN
        check("recover_st", 32'(st_o), 1);
        check("recover_src", 32'(src_o), 0);
`else
        check("terminal_st", 32'(st_o), 4);
        check("terminal_src", 32'(src_o), 32'h05);
`endif
        // async reset mid-ACTIVE
        rst_n = 1'b0; tick();
        rst_n = 1'b1; init = 1'b1; tick(); tick();
        init = 1'b0; femp = 5'h1B; tick();
        check("pre_rst", 32'(st_o), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_st", 32'(st_o), 0);
        check("async_flags", {err_o, act_o, idle_o, init_o}, 0);
        check("async_thr", {3'b0, src_o, umf_o, uvc_o, ud_o}, 0);
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fsm_flow_ctrl_param.md
Name: fsm_flow_ctrl_param

Overview:
Parametrised successor of the five-FIFO flow-control state machine. It supervises NUM_FIFOS FIFOs and programs three threshold registers (UMF, UVC, UD) during initialisation. It reports reset, init, idle, active and error status to the datapath. New over the previous generation: per-FIFO sticky error capture, threshold clamping, an idle hysteresis counter, and an encoded state output.

Parameters:
NUM_FIFOS, 5, number of supervised FIFOs (width of the FIFO_ERROR, FIFO_EMPTY and error_src buses)
TH_W, 8, width of each threshold
MAX_TH, 8'd255, upper clamp applied to every captured threshold (must fit in TH_W)
IDLE_HOLD, 2, consecutive all-empty cycles required for ACTIVE->IDLE; 0 means immediate

Ports:
clk  in  1  system clock, all state on the rising edge
reset  in  1  asynchronous, active-low reset
init  in  1  request (re)initialisation and threshold capture
UMF  in  TH_W  main-FIFO threshold value to capture
UVC  in  TH_W  virtual-channel threshold value to capture
UD  in  TH_W  destination threshold value to capture
FIFO_ERROR  in  NUM_FIFOS  per-FIFO overflow/underflow error, level
FIFO_EMPTY  in  NUM_FIFOS  per-FIFO empty flag, level
UMF_OUT  out  TH_W  programmed main-FIFO threshold
UVC_OUT  out  TH_W  programmed VC threshold
UD_OUT  out  TH_W  programmed destination threshold
error_out  out  1  high while in ERROR
active_out  out  1  high while in ACTIVE
idle_out  out  1  high while in IDLE
init_out  out  1  high while in INIT
state_out  out  3  encoded state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4
error_src  out  NUM_FIFOS  sticky OR of FIFO_ERROR bits seen since leaving RESET

Behaviour:
- reset low (async): state=RESET; all outputs 0, including thresholds, error_src and the idle counter.
- All outputs are registered and updated in the same edge as the state; flags are a one-hot decode of the registered state; latency from input to flag is 1 clk.
- Any error is the OR-reduction of FIFO_ERROR. All empty means FIFO_EMPTY is all ones.
- Transition priority in every state except RESET: error > init > the state's own rule.
- RESET: the first edge with reset high moves to INIT.
- INIT: each cycle, UMF_OUT=min(UMF,MAX_TH); UVC_OUT and UD_OUT are clamped the same way. While init=1, stay in INIT. When init=0: go to IDLE if all FIFOs are empty, else go to ACTIVE. The exit cycle also captures thresholds.
- IDLE: any FIFO not empty -> ACTIVE.
- ACTIVE: idle_cnt increments while all FIFOs are empty, saturating at IDLE_HOLD, and clears on any non-empty cycle. Go to IDLE on the edge where all FIFOs are empty and idle_cnt==IDLE_HOLD (IDLE_HOLD=0 gives the same edge). idle_cnt clears on every ACTIVE exit.
- ERROR: error_src |= FIFO_ERROR every cycle, including the entry cycle. init and the empty flags are ignored. The only exit is reset, unless the optional feature below is compiled in.
- Threshold outputs hold their values outside INIT, including in ERROR.
- error_src accumulates in every state, clears only on reset (see Optional Feature for the other exception), and never clears on INIT.
- init asserted in IDLE or ACTIVE moves to INIT and recaptures the thresholds.
- Reset asserted mid-operation forces RESET immediately, independent of clk.

Optional Feature:
- Macro: FSM_ERR_RECOVERY_EN.
- Defined: in ERROR, if init=1 and FIFO_ERROR==0, go to INIT next edge and clear error_src on that edge.
- Not defined: ERROR is terminal until reset; error_src clears only on reset.

Test Plan:
- Reset, then release with init=1, UMF=8'h10, UVC=8'h20, UD=8'h30 for 3 cycles, then init=0, FIFO_EMPTY=5'h1F -> state_out 0,1,1,1,2; outputs 10/20/30; idle_out=1.
- Clamp: MAX_TH=8'h40, UMF=8'hFF during INIT -> UMF_OUT=8'h40.
- In IDLE, FIFO_EMPTY=5'h1B -> ACTIVE next edge. Then FIFO_EMPTY=5'h1F with IDLE_HOLD=2 -> IDLE on the 3rd all-empty edge. A non-empty pulse on cycle 2 restarts the count.
- In ACTIVE, FIFO_ERROR=5'b00100 for 1 cycle with init=1 simultaneously -> ERROR (error beats init), error_src=5'b00100. A later FIFO_ERROR=5'b00001 -> error_src=5'b00101. Thresholds unchanged.
- Without the macro: ERROR with init=1, FIFO_ERROR=0 -> stays ERROR. With the macro: -> INIT next edge, error_src=0.
- Reset low asserted mid-ACTIVE between clock edges -> all outputs 0 and state_out=0 before the next edge.
